// File: rtl/bus_cycle_ctrl_pkg.sv
// bus_cycle_ctrl_pkg: shared state encoding, region indices and wait-state slicing
package bus_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SECOND = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam int ROM  = 0;
    localparam int RAM  = 1;
    localparam int CPLD = 2;
    localparam int ATA  = 3;

    localparam int WS_MAX = 16;

    function automatic logic [WS_MAX-1:0] ws_of(input logic [63:0] vec, input int r, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return WS_MAX'((vec >> (r * w)) & mask);
    endfunction

endpackage

// File: rtl/ws_counter.sv
// ws_counter: loadable wait-state down-counter that holds at zero
module ws_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    // load wins over decrement; decrement never wraps below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: region-decoded bus cycle sequencer with per-region wait states and 16-bit splitting
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int                     N_CS   = 4,
    parameter int                     WS_W   = 3,
    parameter logic [N_CS*WS_W-1:0]   WAIT   = {3'd3, 3'd0, 3'd1, 3'd2},
    parameter logic [N_CS-1:0]        HALF16 = 4'b0001
) (
    input  logic            clk,
    input  logic            RESETb,
    input  logic            ADSb,
    input  logic            WR,
    input  logic [3:0]      BEb,
    input  logic [N_CS-1:0] sel,
    output logic            READYb,
    output logic [N_CS-1:0] CSb,
    output logic            OEb,
    output logic            WEb,
    output logic            A1,
    output logic [1:0]      STATE
);

    localparam int IW = (N_CS > 1) ? $clog2(N_CS) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] ACCESS = ST_ACCESS;
    localparam logic [1:0] SECOND = ST_SECOND;
    localparam logic [1:0] END    = ST_END;

    logic [1:0]      state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   r_q;
    logic            onehot;
    logic            upper;
    logic            split_in;
    logic            split_q;
    logic [WS_W-1:0] ws_tab [N_CS];
    logic            load;
    logic            dec;
    logic            zero;
    logic [WS_W-1:0] load_val;
    logic [WS_W-1:0] cnt;

    for (genvar g = 0; g < N_CS; g++) begin : g_ws
        assign ws_tab[g] = WS_W'(ws_of(64'(WAIT), g, WS_W));
    end

    // one-hot validity, binary region index and 16-bit half selection of the incoming access
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_CS; i++) if (sel[i]) idx = IW'(i);
        onehot   = $onehot(sel);
        upper    = HALF16[idx] && (BEb[1:0] == 2'b11);
        split_in = HALF16[idx] && (BEb[1:0] != 2'b11) && (BEb[3:2] != 2'b11);
    end

    // counter is loaded on a claimed address strobe and again for the second half of a split
    always_comb begin
        load     = ((state == IDLE) && !ADSb && onehot) || ((state == ACCESS) && zero && split_q);
        load_val = (state == IDLE) ? ws_tab[idx] : ws_tab[r_q];
        dec      = ((state == ACCESS) || (state == SECOND)) && !zero;
    end

    ws_counter #(.W(WS_W)) u_cnt (
        .clk      (clk),
        .rst_n    (RESETb),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt      (cnt),
        .zero     (zero)
    );

    // cycle sequencing with all bus outputs registered; address strobes outside IDLE are ignored
    always_ff @(posedge clk or negedge RESETb) begin
        if (!RESETb) begin
            state   <= IDLE;
            READYb  <= 1'b1;
            CSb     <= '1;
            OEb     <= 1'b1;
            WEb     <= 1'b1;
            A1      <= 1'b0;
            r_q     <= '0;
            split_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!ADSb) begin
                    r_q     <= idx;
                    split_q <= split_in;
                    if (onehot) begin
                        state <= ACCESS;
                        CSb   <= ~sel;
                        OEb   <= WR;
                        WEb   <= !WR;
                        A1    <= upper;
                    end else begin
                        state  <= END;
                        READYb <= 1'b0;
                    end
                end
                ACCESS: if (zero) begin
                    if (split_q) begin
                        state <= SECOND;
                        A1    <= 1'b1;
                    end else begin
                        state  <= END;
                        READYb <= 1'b0;
                        WEb    <= 1'b1;
                    end
                end
                SECOND: if (zero) begin
                    state  <= END;
                    READYb <= 1'b0;
                    WEb    <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    READYb <= 1'b1;
                    CSb    <= '1;
                    OEb    <= 1'b1;
                    WEb    <= 1'b1;
                    A1     <= 1'b0;
                end
            endcase
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: scoreboarded cycle-by-cycle check of bus_cycle_ctrl
module tb_bus_cycle_ctrl;

    logic       clk    = 1'b0;
    logic       RESETb = 1'b1;
    logic       ADSb   = 1'b1;
    logic       WR     = 1'b0;
    logic [3:0] BEb    = 4'hF;
    logic [3:0] sel    = 4'h0;
    logic       READYb;
    logic [3:0] CSb;
    logic       OEb;
    logic       WEb;
    logic       A1;
    logic [1:0] STATE;

    int nvec = 0;
    int nerr = 0;

    int waits[4] = '{2, 1, 0, 3};
    bit half[4]  = '{1, 0, 0, 0};

    typedef struct {
        logic [3:0] cs;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bus_cycle_ctrl #(
        .N_CS   (4),
        .WS_W   (3),
        .WAIT   ({3'd3, 3'd0, 3'd1, 3'd2}),
        .HALF16 (4'b0001)
    ) dut (
        .clk    (clk),
        .RESETb (RESETb),
        .ADSb   (ADSb),
        .WR     (WR),
        .BEb    (BEb),
        .sel    (sel),
        .READYb (READYb),
        .CSb    (CSb),
        .OEb    (OEb),
        .WEb    (WEb),
        .A1     (A1),
        .STATE  (STATE)
    );

    // drive one bus cycle at a negedge and follow it until the bus is idle again
    task automatic run_cycle(input logic [3:0] s, input logic w, input logic [3:0] be, input bit pulse);
        exp_t e;
        exp_t got;
        int r, wt, j;
        bit valid, upper, split, done;
        logic eoe, ewe, ea1;
        valid = $onehot(s);
        r = 0;
        for (int i = 0; i < 4; i++) if (s[i]) r = i;
        wt    = waits[r];
        upper = valid && half[r] && (be[1:0] == 2'b11);
        split = valid && half[r] && (be[1:0] != 2'b11) && (be[3:2] != 2'b11);
        e.cs  = valid ? ~s : 4'hF;
        e.lat = !valid ? 1 : split ? 3 + 2 * wt : 2 + wt;
        eoe   = valid ? w : 1'b1;
        ewe   = valid ? !w : 1'b1;
        sb.push_back(e);
        ADSb = 1'b0; sel = s; WR = w; BEb = be;
        @(posedge clk);
        @(negedge clk);
        ADSb = 1'b1; sel = 4'h0; BEb = 4'hF;
        j = 0;
        done = 1'b0;
        while (!done && j < 40) begin
            if (READYb === 1'b0) begin
                got = sb.pop_front();
                nvec++; if (j + 1 != got.lat) begin nerr++; $display("FAIL latency sel=%b got %0d want %0d", s, j + 1, got.lat); end
                nvec++; if (CSb !== got.cs) begin nerr++; $display("FAIL end_cs sel=%b got %b want %b", s, CSb, got.cs); end
                nvec++; if (OEb !== eoe) begin nerr++; $display("FAIL end_oe sel=%b got %b want %b", s, OEb, eoe); end
                nvec++; if (WEb !== 1'b1) begin nerr++; $display("FAIL end_we sel=%b got %b want 1", s, WEb); end
                nvec++; if (A1 !== (upper || split)) begin nerr++; $display("FAIL end_a1 sel=%b got %b want %b", s, A1, upper || split); end
                nvec++; if (STATE !== 2'd3) begin nerr++; $display("FAIL end_state sel=%b got %0d want 3", s, STATE); end
                done = 1'b1;
            end else begin
                ea1 = upper || (split && j >= 1 + wt);
                nvec++; if (CSb !== e.cs) begin nerr++; $display("FAIL cs sel=%b j=%0d got %b want %b", s, j, CSb, e.cs); end
                nvec++; if (OEb !== eoe) begin nerr++; $display("FAIL oe sel=%b j=%0d got %b want %b", s, j, OEb, eoe); end
                nvec++; if (WEb !== ewe) begin nerr++; $display("FAIL we sel=%b j=%0d got %b want %b", s, j, WEb, ewe); end
                nvec++; if (A1 !== ea1) begin nerr++; $display("FAIL a1 sel=%b j=%0d got %b want %b", s, j, A1, ea1); end
                if (pulse && j == 1) begin ADSb = 1'b0; sel = 4'b0010; end
                if (pulse && j == 2) begin ADSb = 1'b1; sel = 4'h0; end
            end
            @(negedge clk);
            j++;
        end
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL ready_timeout sel=%b got none want READYb low", s);
            sb.delete();
            ADSb = 1'b1;
        end
        nvec++; if (CSb !== 4'hF) begin nerr++; $display("FAIL idle_cs got %b want 1111", CSb); end
        nvec++; if (READYb !== 1'b1) begin nerr++; $display("FAIL idle_ready got %b want 1", READYb); end
        nvec++; if ({OEb, WEb, A1} !== 3'b110) begin nerr++; $display("FAIL idle_strobes got %b want 110", {OEb, WEb, A1}); end
        nvec++; if (STATE !== 2'd0) begin nerr++; $display("FAIL idle_state got %0d want 0", STATE); end
    endtask

    task automatic test_reset();
        #1 RESETb = 1'b0;
        #1;
        nvec++; if (CSb !== 4'hF) begin nerr++; $display("FAIL rst_cs got %b want 1111", CSb); end
        nvec++; if ({READYb, OEb, WEb, A1} !== 4'b1110) begin nerr++; $display("FAIL rst_out got %b want 1110", {READYb, OEb, WEb, A1}); end
        nvec++; if (STATE !== 2'd0) begin nerr++; $display("FAIL rst_state got %0d want 0", STATE); end
        @(negedge clk);
        @(negedge clk);
        RESETb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        run_cycle(4'b0010, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_rom_split();
        run_cycle(4'b0001, 1'b0, 4'b0000, 1'b0);
        run_cycle(4'b0001, 1'b0, 4'b0011, 1'b0);
        run_cycle(4'b0001, 1'b0, 4'b1100, 1'b0);
    endtask

    task automatic test_cpld_write();
        run_cycle(4'b0100, 1'b1, 4'b0000, 1'b0);
    endtask

    task automatic test_unclaimed();
        run_cycle(4'b0110, 1'b0, 4'b0000, 1'b0);
        run_cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
    endtask

    task automatic test_ignore_ads();
        run_cycle(4'b1000, 1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        nvec++; if (CSb !== 4'hF || STATE !== 2'd0) begin nerr++; $display("FAIL ignored_ads got cs=%b st=%0d want cs=1111 st=0", CSb, STATE); end
    endtask

    task automatic test_back_to_back();
        run_cycle(4'b0100, 1'b0, 4'b0000, 1'b0);
        run_cycle(4'b0010, 1'b1, 4'b0000, 1'b0);
        run_cycle(4'b1000, 1'b1, 4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        ADSb = 1'b0; sel = 4'b0001; WR = 1'b0; BEb = 4'b0000;
        @(negedge clk);
        ADSb = 1'b1; sel = 4'h0; BEb = 4'hF;
        cyc = 0;
        while (STATE !== 2'd2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        nvec++; if (STATE !== 2'd2) begin nerr++; $display("FAIL reach_second got %0d want 2", STATE); end
        @(posedge clk);
        #2 RESETb = 1'b0;
        #1;
        nvec++; if (CSb !== 4'hF) begin nerr++; $display("FAIL midrst_cs got %b want 1111", CSb); end
        nvec++; if ({READYb, OEb, WEb, A1} !== 4'b1110) begin nerr++; $display("FAIL midrst_out got %b want 1110", {READYb, OEb, WEb, A1}); end
        nvec++; if (STATE !== 2'd0) begin nerr++; $display("FAIL midrst_state got %0d want 0", STATE); end
        @(negedge clk);
        nvec++; if (READYb !== 1'b1) begin nerr++; $display("FAIL midrst_ready got %b want 1", READYb); end
        RESETb = 1'b1;
        @(negedge clk);
        run_cycle(4'b0010, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_rom_split();
        test_cpld_write();
        test_unclaimed();
        test_ignore_ads();
        test_back_to_back();
        test_reset_mid();
        nvec++;
        if (sb.size() != 0) begin nerr++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Parametrised i386-style bus cycle controller that replaces the fixed GAL glue logic. It receives an externally decoded one-hot region select and drives per-region chip selects, read/write strobes and `READYb`. Each region has its own wait-state count, and 16-bit regions get automatic two-phase splitting of 32-bit accesses (A1 sequencing). It sits between the CPU local bus and the ROM/RAM/CPLD/ATA devices.

## Interface
Parameters:
- `N_CS`, 4: number of regions/chip selects.
- `WS_W`, 3: wait-state counter width.
- `WAIT`, {3'd3,3'd0,3'd1,3'd2}: packed `N_CS*WS_W` bits, region r at bits `[r*WS_W +: WS_W]`. Default gives region0=2, region1=1, region2=0, region3=3.
- `HALF16`, 4'b0001: bit r=1 means region r is 16 bits wide and needs split cycles.

Ports:
- `clk`  in  1  clock.
- `RESETb`  in  1  reset, asynchronous, active-low.
- `ADSb`  in  1  address strobe, active-low, sampled on rising `clk`.
- `WR`  in  1  1=write, 0=read; sampled with `ADSb`.
- `BEb`  in  4  byte enables, active-low; sampled with `ADSb`.
- `sel`  in  `N_CS`  one-hot region decode; sampled with `ADSb`.
- `READYb`  out  1  cycle termination, active-low, registered.
- `CSb`  out  `N_CS`  chip selects, active-low.
- `OEb`  out  1  read strobe, active-low.
- `WEb`  out  1  write strobe, active-low.
- `A1`  out  1  half-word address for 16-bit regions.
- `STATE`  out  2  current state encoding, for debug.

## Operation
- States: IDLE=0, ACCESS=1, SECOND=2, END=3. All outputs are registered.
- Reset (async, immediate): state=IDLE, `READYb`=1, `CSb`=all 1, `OEb`=1, `WEb`=1, `A1`=0, counter=0.
- IDLE, with `ADSb`=0 at an edge:
  - Latch `sel`, `WR` and `BEb`.
  - If `sel` is exactly one-hot (region r): `CSb[r]`=0, `OEb`=`WR`, `WEb`=!`WR`, cnt=`WAIT[r]`, go to ACCESS.
  - Otherwise (zero or multiple bits set): go straight to END with no CS asserted. This is unclaimed termination; read data is undefined.
- A1 on entry:
  - A1=1 if `HALF16[r]` is set and `BEb[1:0]`=2'b11 (upper half only).
  - Else A1=0.
- split = `HALF16[r]` and `BEb[1:0]`!=2'b11 and `BEb[3:2]`!=2'b11.
- ACCESS:
  - cnt!=0: cnt-1.
  - cnt==0 and split: A1=1, cnt=`WAIT[r]`, go to SECOND. CS and strobes stay asserted.
  - cnt==0 and not split: go to END.
- SECOND: cnt!=0: cnt-1. cnt==0: go to END.
- END:
  - `READYb`=0 for exactly one cycle.
  - `CSb` and `OEb` are held.
  - `WEb`=1 for write data hold.
  - Next edge: IDLE, all outputs inactive, A1=0.
- `ADSb` asserted in any state other than IDLE is ignored, with no latching.
- Counter saturates at 0 and never wraps.

## Timing
- `ADSb` is sampled low at edge k:
  - CS/strobes are valid after edge k.
  - Non-split: `READYb` is low between edges k+1+W and k+2+W. The CPU samples it at edge k+2+W.
  - Split: `READYb` is sampled at edge k+3+2W. A1 rises after edge k+1+W.
  - Unclaimed: `READYb` is sampled at edge k+1.
- Back-to-back: a new `ADSb` is accepted at the edge that leaves END (state returns to IDLE) plus one. Minimum idle is one cycle between cycles.
- Reset mid-cycle: outputs go inactive without waiting for an edge. No `READYb` pulse is emitted.

## Structure
- `bus_cycle_ctrl_pkg`: state enum (IDLE/ACCESS/SECOND/END), region index constants (ROM=0, RAM=1, CPLD=2, ATA=3), and a `ws_of(r)` helper for slicing `WAIT`.
- One sub-module, `ws_counter`: loadable down-counter of width `WS_W` with a `zero` flag.
- One-hot check and encode stay in the top.

## Test plan
- RAM read, region1, W=1, BEb=0000: `CSb`=4'b1101, `OEb`=0 from edge k. `READYb` sampled low at edge k+3. `WEb` stays 1.
- ROM read, region0, split, W=2, BEb=0000: A1=0 for 3 cycles then A1=1. `READYb` sampled low at edge k+7. CSb[0] is low throughout.
- ROM read, BEb=0011: no split, A1=1 from edge k, `READYb` at edge k+4.
- CPLD write, region2, W=0: `WEb`=0 for one cycle, then 1 while `READYb`=0. `READYb` sampled at edge k+2.
- `sel`=4'b0110 (invalid): no CS asserted, `READYb` sampled low at edge k+1. `ADSb` pulsed during an ATA cycle (W=3) is ignored.
- `RESETb` dropped in SECOND: all outputs inactive immediately. After release, a fresh RAM read completes normally.
